fetch_prefetch: RTL
===================

Name: fetch_prefetch

Overview:
Parametrised instruction-fetch stage. Owns the PC, issues in-order word reads to an external variable-latency instruction memory, and buffers returned instructions in a DEPTH-entry prefetch FIFO. Hands {pc, ir, pc+1} to decode over a valid/ready handshake. Replaces the externally-selected PC mux with NUM_REDIRECT prioritised redirect channels, which flush the buffer and squash any in-flight read.

Parameters:
WIDTH, 16, PC and instruction width in bits
DEPTH, 4, prefetch FIFO entries (>=2)
NUM_REDIRECT, 5, redirect channels; higher index = later pipeline stage = higher priority
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high
redirect_valid  in  NUM_REDIRECT  per-channel redirect request
redirect_pc  in  NUM_REDIRECT*WIDTH  channel i target at bits [i*WIDTH +: WIDTH]
imem_req  out  1  read request, one-cycle pulse per read
imem_addr  out  WIDTH  read address, valid when imem_req
imem_rvalid  in  1  read data valid; at least 1 cycle after request, in order
imem_rdata  in  WIDTH  instruction word
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_pc  out  WIDTH  PC of head instruction
out_ir  out  WIDTH  head instruction word
out_pc_inc  out  WIDTH  out_pc+1, mod 2^WIDTH
pc_out  out  WIDTH  current fetch PC (next address to request)
fill_count  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async) sets: fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0. Outputs imem_req=0, out_valid=0, fill_count=0, pc_out=RESET_PC. out_pc, out_ir, out_pc_inc are don't-care while out_valid=0.
- Redirect selection: sel = highest index i with redirect_valid[i]=1; redirect = |redirect_valid.
- At most one memory read is outstanding.
- pop = out_valid & out_ready.
- out_valid = (fill_count!=0) & ~redirect. The head is never consumed in a redirect cycle.
- Issue condition: issue = ~redirect & (~outstanding | imem_rvalid) & ((fill_count + outstanding < DEPTH) | pop).
  - imem_req = issue; imem_addr = fetch_pc.
- On issue: req_pc <= fetch_pc; fetch_pc <= fetch_pc+1, wrapping all-ones to 0; outstanding <= 1.
- On imem_rvalid with outstanding=1:
  - discard=0 and no redirect this cycle: push {req_pc, imem_rdata}.
  - otherwise drop the word.
  - Either way, discard <= 0, and outstanding <= issue.
- imem_rvalid while outstanding=0 (e.g. a stale reply after reset) is ignored.
- Push and pop in the same cycle: fill_count unchanged; the FIFO never overflows or underflows by construction.
- Minimum latency: request at cycle t, rvalid at t+1, out_valid at t+2. With 1-cycle memory and a draining consumer, throughput is 1 instruction per cycle.
- On redirect:
  - fetch_pc <= redirect_pc[sel]; FIFO flushed (fill_count <= 0); no issue this cycle.
  - If outstanding=1 and imem_rvalid=0: discard <= 1. Outstanding stays set until the stale reply arrives; issue resumes in the reply cycle at the new PC.
  - Redirect while discard is already 1: discard stays 1, fetch_pc takes the newest target.
- Simultaneous redirect on several channels: only sel applies; the rest are ignored.
- Reset mid-flight: all state cleared immediately; the later reply is ignored per the outstanding=0 rule.

Test Plan:
- Reset, RESET_PC=0x0000, 1-cycle memory returning rdata=addr^0xA5A5, out_ready=1 -> requests 0,1,2...; first out_valid 2 cycles after reset release with out_pc=0, out_ir=0xA5A5, out_pc_inc=1; then one instruction per cycle.
- out_ready=0 with DEPTH=4 -> fill_count saturates at 4, imem_req stops. Raise out_ready -> entries 0..3 pop in order, fetch resumes at 4 without loss or duplication.
- Read to 0x0010 outstanding with 3-cycle memory; redirect ch1 to 0x0200 in the cycle after request -> stale word dropped, FIFO empty, next imem_addr=0x0200 issued in the stale rvalid cycle, first out_pc=0x0200.
- Same cycle: redirect_valid=5'b00101 with ch0=0x0100, ch2=0x0300 -> fetch resumes at 0x0300; out_valid=0 in that cycle even though FIFO was non-empty.
- fetch_pc=0xFFFF -> request 0xFFFF then 0x0000; out_pc_inc of 0xFFFF entry = 0x0000.
- Assert reset while a read is outstanding, deassert before rvalid -> stray rvalid ignored, fill_count stays 0, first request to RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order reads to a
// variable-latency instruction memory and buffers replies in a small FIFO.
module fetch_prefetch #(
    parameter int              WIDTH        = 16,
    parameter int              DEPTH        = 4,
    parameter int              NUM_REDIRECT = 5,
    parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REDIRECT-1:0]       redirect_valid,
    input  logic [NUM_REDIRECT*WIDTH-1:0] redirect_pc,
    output logic                          imem_req,
    output logic [WIDTH-1:0]              imem_addr,
    input  logic                          imem_rvalid,
    input  logic [WIDTH-1:0]              imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_pc,
    output logic [WIDTH-1:0]              out_ir,
    output logic [WIDTH-1:0]              out_pc_inc,
    output logic [WIDTH-1:0]              pc_out,
    output logic [$clog2(DEPTH+1)-1:0]    fill_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW:0]   CAPACITY = (CW + 1)'(DEPTH);

    // Architectural state
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] req_pc_q,   req_pc_d;
    logic             outst_q,    outst_d;
    logic             discard_q,  discard_d;

    // FIFO bookkeeping
    logic [PW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]    count_q,    count_d;

    // FIFO storage (data only, no reset needed)
    logic [WIDTH-1:0] pc_mem [DEPTH];
    logic [WIDTH-1:0] ir_mem [DEPTH];

    // Control terms
    logic             redirect;
    logic [WIDTH-1:0] redir_target;
    logic             reply;
    logic             push;
    logic             pop;
    logic             issue;
    logic             has_room;
    logic             port_free;
    logic [CW:0]      inflight;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Pick the highest-indexed (latest pipeline stage) active redirect
    always_comb begin
        redir_target = '0;
        for (int i = 0; i < NUM_REDIRECT; i++) begin
            if (redirect_valid[i]) begin
                redir_target = redirect_pc[i*WIDTH +: WIDTH];
            end
        end
    end

    assign redirect = |redirect_valid;

    // A reply only counts when we actually have a read in flight;
    // anything else is a leftover from before a reset.
    assign reply = imem_rvalid & outst_q;
    assign push  = reply & ~discard_q & ~redirect;

    assign out_valid = (count_q != '0) & ~redirect;
    assign pop       = out_valid & out_ready;

    // Slots already promised = buffered words plus the read in flight
    assign inflight  = {1'b0, count_q} + (CW + 1)'(outst_q);
    assign has_room  = (inflight < CAPACITY) | pop;
    assign port_free = ~outst_q | imem_rvalid;
    assign issue     = ~reset & ~redirect & port_free & has_room;

    assign imem_req  = issue;
    assign imem_addr = fetch_pc_q;
    assign pc_out    = fetch_pc_q;

    assign fill_count = count_q;

    assign out_pc     = pc_mem[rd_ptr_q];
    assign out_ir     = ir_mem[rd_ptr_q];
    assign out_pc_inc = out_pc + 1'b1;

    // Next-state for PC, read tracking and FIFO pointers
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (reply) begin
            discard_d = 1'b0;
            outst_d   = 1'b0;
        end

        if (issue) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 1'b1;
            outst_d    = 1'b1;
        end

        if (redirect) begin
            fetch_pc_d = redir_target;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            // The in-flight word belongs to the old path; drop it on arrival
            if (outst_q && !imem_rvalid) begin
                discard_d = 1'b1;
            end
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            outst_q    <= 1'b0;
            discard_q  <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Write accepted instruction words into the FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q] <= req_pc_q;
            ir_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule
